// File: rtl/control_pkg.sv
// Shared definitions for the control-word sequencer: field layout, encodings and the FETCH word.
package control_pkg;

  localparam int unsigned CW_WIDTH = 33;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ALUFS_W  = 5;
  localparam int unsigned PCFS_W   = 2;
  localparam int unsigned STATE_W  = 2;
  localparam int unsigned FLAGS_W  = 5;

  // Bit positions, LSB first: next_state sits at the bottom of the word.
  localparam int unsigned NS_LSB      = 0;
  localparam int unsigned SLD_BIT     = 2;
  localparam int unsigned PC_IS_BIT   = 3;
  localparam int unsigned PC_FS_LSB   = 4;
  localparam int unsigned PC_EN_BIT   = 6;
  localparam int unsigned RAM_W_BIT   = 7;
  localparam int unsigned RAM_EN_BIT  = 8;
  localparam int unsigned RF_W_BIT    = 9;
  localparam int unsigned RF_DA_LSB   = 10;
  localparam int unsigned RF_SB_LSB   = 15;
  localparam int unsigned RF_SA_LSB   = 20;
  localparam int unsigned RF_B_EN_BIT = 25;
  localparam int unsigned ALU_FS_LSB  = 26;
  localparam int unsigned ALU_BS_BIT  = 31;
  localparam int unsigned ALU_EN_BIT  = 32;

  localparam logic [PCFS_W-1:0] PC_HOLD = 2'b00;
  localparam logic [PCFS_W-1:0] PC_INC4 = 2'b01;
  localparam logic [PCFS_W-1:0] PC_OFFS = 2'b10;
  localparam logic [PCFS_W-1:0] PC_LOAD = 2'b11;

  localparam logic [ALUFS_W-1:0] ALU_PASS_A = 5'h00;
  localparam logic [ALUFS_W-1:0] ALU_ADD    = 5'h02;
  localparam logic [ALUFS_W-1:0] ALU_SUB    = 5'h05;
  localparam logic [ALUFS_W-1:0] ALU_AND    = 5'h08;
  localparam logic [ALUFS_W-1:0] ALU_OR     = 5'h0A;
  localparam logic [ALUFS_W-1:0] ALU_XOR    = 5'h0C;
  localparam logic [ALUFS_W-1:0] ALU_PASS_B = 5'h14;

  // Instruction fetch drives only the RAM enable; everything else idles.
  localparam logic [CW_WIDTH-1:0] FETCH_CW = CW_WIDTH'(1) << RAM_EN_BIT;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

endpackage

// File: rtl/cw_unpack.sv
// Splits a packed control word into its named datapath fields.
module cw_unpack
  import control_pkg::*;
(
  input  logic [CW_WIDTH-1:0] i_cw,
  output logic                o_alu_en,
  output logic                o_alu_bs,
  output logic [ALUFS_W-1:0]  o_alu_fs,
  output logic                o_rf_b_en,
  output logic [ADDR_W-1:0]   o_rf_sa,
  output logic [ADDR_W-1:0]   o_rf_sb,
  output logic [ADDR_W-1:0]   o_rf_da,
  output logic                o_rf_w,
  output logic                o_ram_en,
  output logic                o_ram_w,
  output logic                o_pc_en,
  output logic [PCFS_W-1:0]   o_pc_fs,
  output logic                o_pc_is,
  output logic                o_status_ld,
  output logic [STATE_W-1:0]  o_next_state
);

  assign o_alu_en     = i_cw[ALU_EN_BIT];
  assign o_alu_bs     = i_cw[ALU_BS_BIT];
  assign o_alu_fs     = i_cw[ALU_FS_LSB +: ALUFS_W];
  assign o_rf_b_en    = i_cw[RF_B_EN_BIT];
  assign o_rf_sa      = i_cw[RF_SA_LSB +: ADDR_W];
  assign o_rf_sb      = i_cw[RF_SB_LSB +: ADDR_W];
  assign o_rf_da      = i_cw[RF_DA_LSB +: ADDR_W];
  assign o_rf_w       = i_cw[RF_W_BIT];
  assign o_ram_en     = i_cw[RAM_EN_BIT];
  assign o_ram_w      = i_cw[RAM_W_BIT];
  assign o_pc_en      = i_cw[PC_EN_BIT];
  assign o_pc_fs      = i_cw[PC_FS_LSB +: PCFS_W];
  assign o_pc_is      = i_cw[PC_IS_BIT];
  assign o_status_ld  = i_cw[SLD_BIT];
  assign o_next_state = i_cw[NS_LSB +: STATE_W];

endmodule

// File: rtl/control_word_sequencer.sv
// Sequences each instruction through FETCH and EXEC, owning IR, execute state, status and
// the retired/fault bookkeeping; unpacks the active control word onto the datapath strobes.
module control_word_sequencer
  import control_pkg::*;
#(
  parameter int unsigned MAX_EXEC_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CW_WIDTH-1:0]    cw_in,
  input  logic [31:0]            instr_in,
  input  logic [FLAGS_W-1:0]     flags_in,
  input  logic                   stall,
  output logic [31:0]            I,
  output logic [STATE_W-1:0]     state,
  output logic [FLAGS_W-1:0]     status,
  output logic                   fetch,
  output logic                   ir_ld,
  output logic                   alu_en,
  output logic                   alu_bs,
  output logic                   rf_b_en,
  output logic                   rf_w,
  output logic                   ram_en,
  output logic                   ram_w,
  output logic                   pc_en,
  output logic                   pc_is,
  output logic [ALUFS_W-1:0]     alu_fs,
  output logic [ADDR_W-1:0]      rf_sa,
  output logic [ADDR_W-1:0]      rf_sb,
  output logic [ADDR_W-1:0]      rf_da,
  output logic [PCFS_W-1:0]      pc_fs,
  output logic [COUNT_WIDTH-1:0] retired,
  output logic                   fault
);

  localparam int unsigned CNT_W = $clog2(MAX_EXEC_CYCLES + 1);

  phase_e                   r_phase;
  logic [STATE_W-1:0]       r_state;
  logic [31:0]              r_i;
  logic [FLAGS_W-1:0]       r_status;
  logic [CNT_W-1:0]         r_exec_cnt;
  logic [COUNT_WIDTH-1:0]   r_retired;
  logic                     r_fault;

  logic [CW_WIDTH-1:0]      w_cw;
  logic                     w_rf_w;
  logic                     w_ram_w;
  logic [PCFS_W-1:0]        w_pc_fs;
  logic                     w_status_ld;
  logic [STATE_W-1:0]       w_next_state;
  logic                     w_fetch;

  assign w_fetch = (r_phase == PH_FETCH);
  assign w_cw    = w_fetch ? FETCH_CW : cw_in;

  cw_unpack u_cw_unpack (
    .i_cw         (w_cw),
    .o_alu_en     (alu_en),
    .o_alu_bs     (alu_bs),
    .o_alu_fs     (alu_fs),
    .o_rf_b_en    (rf_b_en),
    .o_rf_sa      (rf_sa),
    .o_rf_sb      (rf_sb),
    .o_rf_da      (rf_da),
    .o_rf_w       (w_rf_w),
    .o_ram_en     (ram_en),
    .o_ram_w      (w_ram_w),
    .o_pc_en      (pc_en),
    .o_pc_fs      (w_pc_fs),
    .o_pc_is      (pc_is),
    .o_status_ld  (w_status_ld),
    .o_next_state (w_next_state)
  );

  // Stall kills anything that writes state; bus enables stay up so the bus remains driven.
  assign rf_w   = w_rf_w  & ~stall;
  assign ram_w  = w_ram_w & ~stall;
  assign pc_fs  = stall ? PC_HOLD : w_pc_fs;
  assign ir_ld  = w_fetch & ~stall;
  assign fetch  = w_fetch;

  assign I       = r_i;
  assign state   = r_state;
  assign status  = r_status;
  assign retired = r_retired;
  assign fault   = r_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase    <= PH_FETCH;
      r_state    <= '0;
      r_i        <= '0;
      r_status   <= '0;
      r_exec_cnt <= '0;
      r_retired  <= '0;
      r_fault    <= 1'b0;
    end else if (!stall) begin
      case (r_phase)
        PH_FETCH: begin
          r_i        <= instr_in;
          r_phase    <= PH_EXEC;
          r_state    <= '0;
          r_exec_cnt <= CNT_W'(1);
        end
        PH_EXEC: begin
          if (w_status_ld) begin
            r_status <= flags_in;
          end
          if (w_next_state == '0) begin
            r_phase   <= PH_FETCH;
            r_state   <= '0;
            r_retired <= r_retired + COUNT_WIDTH'(1);
          end else if (r_exec_cnt == CNT_W'(MAX_EXEC_CYCLES)) begin
            // Runaway instruction: abandon it without counting it as retired.
            r_phase <= PH_FETCH;
            r_state <= '0;
            r_fault <= 1'b1;
          end else begin
            r_state    <= w_next_state;
            r_exec_cnt <= r_exec_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_phase <= PH_FETCH;
          r_state <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_word_sequencer.sv
// Directed self-checking bench for control_word_sequencer.
module tb_control_word_sequencer;

  logic        clock;
  logic        reset;
  logic [32:0] cw_in;
  logic [31:0] instr_in;
  logic [4:0]  flags_in;
  logic        stall;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        fetch, ir_ld;
  logic        alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is;
  logic [4:0]  alu_fs, rf_sa, rf_sb, rf_da;
  logic [1:0]  pc_fs;
  logic [31:0] retired;
  logic        fault;

  int checks = 0;
  int errors = 0;

  control_word_sequencer #(.MAX_EXEC_CYCLES(4), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .cw_in(cw_in), .instr_in(instr_in),
    .flags_in(flags_in), .stall(stall), .I(I), .state(state), .status(status),
    .fetch(fetch), .ir_ld(ir_ld), .alu_en(alu_en), .alu_bs(alu_bs),
    .rf_b_en(rf_b_en), .rf_w(rf_w), .ram_en(ram_en), .ram_w(ram_w),
    .pc_en(pc_en), .pc_is(pc_is), .alu_fs(alu_fs), .rf_sa(rf_sa),
    .rf_sb(rf_sb), .rf_da(rf_da), .pc_fs(pc_fs), .retired(retired),
    .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packs fields MSB-first in the documented control-word order.
  function automatic logic [32:0] mk_cw(
    input logic alu_en_f, input logic alu_bs_f, input logic [4:0] alu_fs_f,
    input logic rf_b_en_f, input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
    input logic rf_w_f, input logic ram_en_f, input logic ram_w_f, input logic pc_en_f,
    input logic [1:0] pc_fs_f, input logic pc_is_f, input logic sld, input logic [1:0] ns);
    return {alu_en_f, alu_bs_f, alu_fs_f, rf_b_en_f, sa, sb, da,
            rf_w_f, ram_en_f, ram_w_f, pc_en_f, pc_fs_f, pc_is_f, sld, ns};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flags_in = '0; instr_in = '0; cw_in = '0;
    #2;
    check("rst_fetch", 64'(fetch), 64'd1);
    check("rst_ir_ld", 64'(ir_ld), 64'd1);
    check("rst_ram_en", 64'(ram_en), 64'd1);
    check("rst_state", 64'(state), 64'd0);
    check("rst_I", 64'(I), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    tick(); tick();
    reset = 1'b0;

    // Single-cycle instruction.
    instr_in = 32'h8B02_0020;
    cw_in = mk_cw(1'b1, 1'b0, 5'h02, 1'b0, 5'd1, 5'd2, 5'd3,
                  1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00);
    settle();
    check("c1_fetch", 64'(fetch), 64'd1);
    check("c1_ir_ld", 64'(ir_ld), 64'd1);
    check("c1_ram_en", 64'(ram_en), 64'd1);
    check("c1_rf_w", 64'(rf_w), 64'd0);
    check("c1_rf_da", 64'(rf_da), 64'd0);
    check("c1_alu_en", 64'(alu_en), 64'd0);
    tick();
    check("c2_I", 64'(I), 64'h8B02_0020);
    check("c2_rf_w", 64'(rf_w), 64'd1);
    check("c2_state", 64'(state), 64'd0);
    check("c2_fetch", 64'(fetch), 64'd0);
    check("c2_ir_ld", 64'(ir_ld), 64'd0);
    check("c2_rf_da", 64'(rf_da), 64'd3);
    check("c2_alu_fs", 64'(alu_fs), 64'h02);
    check("c2_pc_fs", 64'(pc_fs), 64'd1);
    check("c2_ram_en", 64'(ram_en), 64'd0);
    tick();
    check("c3_fetch", 64'(fetch), 64'd1);
    check("c3_retired", 64'(retired), 64'd1);

    // Status load, then no load with different flags.
    tick();
    cw_in = mk_cw(1'b1, 1'b0, 5'h05, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
    flags_in = 5'b10101;
    tick();
    check("st_load", 64'(status), 64'h15);
    check("st_retired", 64'(retired), 64'd2);
    tick();
    cw_in = mk_cw(1'b1, 1'b0, 5'h05, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    flags_in = 5'b01010;
    tick();
    check("st_hold", 64'(status), 64'h15);

    // Multi-cycle: next_state 01, 10, 00.
    tick();
    cw_in = mk_cw(1'b0, 1'b0, 5'h00, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01);
    settle();
    check("mc_state0", 64'(state), 64'd0);
    tick();
    cw_in[1:0] = 2'b10;
    settle();
    check("mc_state1", 64'(state), 64'd1);
    check("mc_fetch1", 64'(fetch), 64'd0);
    tick();
    cw_in[1:0] = 2'b00;
    settle();
    check("mc_state2", 64'(state), 64'd2);
    tick();
    check("mc_done", 64'(fetch), 64'd1);
    check("mc_retired", 64'(retired), 64'd4);

    // Execute-cycle limit with next_state stuck at 01; status still loads.
    tick();
    cw_in = mk_cw(1'b0, 1'b0, 5'h00, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
    flags_in = 5'b00011;
    tick(); tick(); tick();
    check("lim_still_exec", 64'(fetch), 64'd0);
    check("lim_no_fault", 64'(fault), 64'd0);
    tick();
    check("lim_fetch", 64'(fetch), 64'd1);
    check("lim_fault", 64'(fault), 64'd1);
    check("lim_state", 64'(state), 64'd0);
    check("lim_retired", 64'(retired), 64'd4);
    check("lim_status", 64'(status), 64'h03);

    // Stall mid-EXEC.
    instr_in = 32'h1234_5678;
    flags_in = 5'b11111;
    tick();
    cw_in = mk_cw(1'b1, 1'b0, 5'h0A, 1'b0, 5'd7, 5'd0, 5'd9,
                  1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b01);
    tick();
    stall = 1'b1;
    instr_in = 32'hDEAD_BEEF;
    settle();
    check("stl_rf_w", 64'(rf_w), 64'd0);
    check("stl_ram_w", 64'(ram_w), 64'd0);
    check("stl_pc_fs", 64'(pc_fs), 64'd0);
    check("stl_ram_en", 64'(ram_en), 64'd1);
    check("stl_alu_en", 64'(alu_en), 64'd1);
    check("stl_rf_sa", 64'(rf_sa), 64'd7);
    tick(); tick(); tick();
    check("stl_state", 64'(state), 64'd1);
    check("stl_I", 64'(I), 64'h1234_5678);
    check("stl_retired", 64'(retired), 64'd4);
    check("stl_status", 64'(status), 64'h03);
    stall = 1'b0;
    settle();
    check("rel_rf_w", 64'(rf_w), 64'd1);
    check("rel_ram_w", 64'(ram_w), 64'd1);
    check("rel_pc_fs", 64'(pc_fs), 64'd2);
    check("rel_state", 64'(state), 64'd1);
    cw_in[1:0] = 2'b00;
    tick();
    check("rel_done", 64'(fetch), 64'd1);
    check("rel_retired", 64'(retired), 64'd5);
    check("rel_fault_sticky", 64'(fault), 64'd1);

    // Stall during FETCH blocks the IR load and the phase change.
    stall = 1'b1;
    settle();
    check("sf_ir_ld", 64'(ir_ld), 64'd0);
    check("sf_ram_en", 64'(ram_en), 64'd1);
    tick();
    check("sf_fetch", 64'(fetch), 64'd1);
    stall = 1'b0;

    // Asynchronous reset mid-EXEC.
    tick();
    cw_in = mk_cw(1'b0, 1'b0, 5'h00, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01);
    tick();
    check("ar_pre_state", 64'(state), 64'd1);
    check("ar_pre_retired", 64'(retired), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check("ar_fetch", 64'(fetch), 64'd1);
    check("ar_state", 64'(state), 64'd0);
    check("ar_retired", 64'(retired), 64'd0);
    check("ar_fault", 64'(fault), 64'd0);
    check("ar_status", 64'(status), 64'd0);
    check("ar_I", 64'(I), 64'd0);
    check("ar_rf_w", 64'(rf_w), 64'd0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_word_sequencer.md
Name: control_word_sequencer

Overview:
- Consumes the 33-bit control word produced by the instruction-class decoders and sequences each instruction through a fetch phase and one or more execute cycles.
- Owns the instruction register, the 2-bit execute-state register fed back to the decoders, and the status register.
- Unpacks the control word into individual datapath strobes and gates the write strobes during stalls.
- Sits between the decoder mux and the datapath: register file, ALU, RAM, PC.

Parameters:
CW_WIDTH, 33, control word width; field order {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa[4:0], rf_sb[4:0], rf_da[4:0], rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}
MAX_EXEC_CYCLES, 4, execute cycles allowed per instruction before a forced abort
COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
cw_in  in  33  control word from the selected decoder; valid during EXEC
instr_in  in  32  instruction word from the data bus; valid during FETCH
flags_in  in  5  {V,C,N,Z,zero} from the ALU
stall  in  1  freezes all state; suppresses write strobes
I  out  32  instruction register, drives the decoders
state  out  2  execute sub-state, drives the decoders
status  out  5  status register
fetch  out  1  high in the FETCH phase
ir_ld  out  1  instruction register load strobe
alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is  out  1 each  unpacked control strobes
alu_fs  out  5  ALU function select
rf_sa, rf_sb, rf_da  out  5 each  register file addresses
pc_fs  out  2  PC function (00 hold, 01 +4, 10 +offset, 11 load)
retired  out  COUNT_WIDTH  number of completed instructions
fault  out  1  sticky; execute-cycle limit exceeded

Behaviour:
- Registers: phase (FETCH/EXEC), state[1:0], I, status, exec_cnt, retired, fault.
- Reset (asynchronous, active-high) values: phase=FETCH, state=00, I=0, status=0, exec_cnt=0, retired=0, fault=0. While reset is held, outputs show the FETCH word.
- FETCH word (combinational while phase=FETCH):
  - ram_en=1, ir_ld=1, fetch=1.
  - All other strobes 0, pc_fs=00, addresses 0, alu_fs=0.
- EXEC word (combinational while phase=EXEC): outputs are the fields of cw_in, passed straight through; ir_ld=0, fetch=0.
- FETCH edge (stall=0): I<=instr_in, phase<=EXEC, state<=00, exec_cnt<=1. Fetch takes exactly 1 cycle.
- EXEC edge (stall=0):
  - state<=cw_in.next_state.
  - If cw_in.status_ld: status<=flags_in.
  - If next_state==00: phase<=FETCH, retired<=retired+1 (wraps modulo 2^COUNT_WIDTH).
  - Otherwise: exec_cnt<=exec_cnt+1.
- Single-cycle instruction (next_state=00 on the first EXEC cycle) therefore takes 2 clocks total.
- Execute-cycle limit: if exec_cnt==MAX_EXEC_CYCLES and next_state!=00, then phase<=FETCH, state<=00, fault<=1. retired is NOT incremented. status still loads if status_ld.
- fault clears only on reset.
- Stall (stall=1):
  - No register changes.
  - rf_w, ram_w, ir_ld forced 0; pc_fs forced 00.
  - Bus enables (ram_en, alu_en, rf_b_en, pc_en), addresses and alu_fs pass unchanged, so the bus stays driven.
- Simultaneous events:
  - reset overrides stall and all updates.
  - stall overrides the limit abort; the abort is evaluated on the first unstalled edge.
- Reset asserted mid-EXEC: immediate return to FETCH with state=00; a partially executed instruction is not counted.
- Only one of FETCH/EXEC is active at any time; the output mux is purely combinational from phase, stall and cw_in. No added latency.

Decomposition:
- Shared package control_pkg holds:
  - Control word field offsets/widths and CW_WIDTH.
  - pc_fs encodings (PC_HOLD, PC_INC4, PC_OFFS, PC_LOAD).
  - ALU function encodings.
  - The FETCH control-word constant.
  - Phase encoding.
- One sub-module: cw_unpack, which splits a CW_WIDTH vector into the named fields (combinational). Used both for cw_in and for the FETCH constant.

Test Plan:
- Reset, then release; instr_in=0x8B020020; cw_in with next_state=00, rf_w=1 -> cycle 1: fetch=1, ir_ld=1, ram_en=1. Cycle 2: I=0x8B020020, rf_w=1, state=00. Cycle 3: fetch=1, retired=1.
- cw_in.status_ld=1, flags_in=5'b10101 during EXEC -> status=5'b10101 after the edge; with status_ld=0 and new flags, status unchanged.
- Multi-cycle: next_state sequence 01,10,00 -> state outputs 00,01,10 on the EXEC cycles; 4 clocks total; retired increments once.
- next_state held at 01 with MAX_EXEC_CYCLES=4 -> after the 4th EXEC cycle phase=FETCH, fault=1, retired unchanged.
- stall=1 for 3 cycles mid-EXEC with rf_w=1, ram_w=1 -> rf_w=ram_w=0, pc_fs=00, state/I/retired frozen. Release -> resumes the same EXEC cycle with strobes restored.
- Assert reset mid-EXEC with retired=5 -> asynchronous clear: fetch=1, state=00, retired=0, fault=0, status=0.
